// File: rtl/screen_bus_seq.sv
// Z88 screen sequencer: clock-enable divider, one-hot 3-phase cycle, grey/flash timebases and screen/CPU bus arbitration.
// Optional macro LCD_PHASE_SYNC_EN: lcdon only changes on the ph2->ph0 clk_ena so an SBA LSB/MSB pair is never split.
module screen_bus_seq #(
  parameter int CLK_DIV  = 4,
  parameter int T5_TICKS = 16384,
  parameter int FLS_DIV  = 200
) (
  input  logic        clk,
  input  logic        rin,
  input  logic        lcdon_req,
  output logic        lcdon,
  output logic        clk_ena,
  output logic [2:0]  clk_ph,
  output logic [2:0]  clk_ph_adv,
  output logic        t_5ms,
  output logic        t_1s,
  input  logic [21:0] scr_va,
  input  logic [21:0] cpu_a,
  input  logic        cpu_req,
  input  logic        cpu_we,
  output logic        cpu_ack,
  output logic        cpu_wait,
  output logic [21:0] mem_a,
  output logic        mem_we,
  output logic        mem_owner
);

  localparam int DW  = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
  localparam int T5W = (T5_TICKS > 1) ? $clog2(T5_TICKS) : 1;
  localparam int FLW = (FLS_DIV  > 1) ? $clog2(FLS_DIV)  : 1;

  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]  ADV_AT   = DW'(CLK_DIV / 2 - 1);
  localparam logic [T5W-1:0] T5_LAST  = T5W'(T5_TICKS - 1);
  localparam logic [FLW-1:0] FL_LAST  = FLW'(FLS_DIV - 1);

  logic [DW-1:0]  r_div;
  logic           r_clk_ena;
  logic [2:0]     r_ph;
  logic [2:0]     r_ph_adv;
  logic [T5W-1:0] r_t5_cnt;
  logic [FLW-1:0] r_t1_cnt;
  logic           r_t_5ms;
  logic           r_t_1s;
  logic           r_lcdon;
  logic           r_cpu_ack;

  logic [DW-1:0]  w_div_nxt;
  logic           w_mem_owner;
  logic           w_lcd_upd;

  assign w_div_nxt   = (r_div == DIV_LAST) ? '0 : r_div + DW'(1);
  assign w_mem_owner = ~r_lcdon | r_ph[2];

`ifdef LCD_PHASE_SYNC_EN
  assign w_lcd_upd = r_clk_ena & r_ph[2];
`else
  assign w_lcd_upd = r_clk_ena;
`endif

  // clk_ena is registered from the next count so it is high while r_div == CLK_DIV-1;
  // the advanced phase then turns CLK_DIV/2 clocks ahead of clk_ph.
  always_ff @(posedge clk) begin
    if (rin) begin
      r_div     <= '0;
      r_clk_ena <= 1'b0;
      r_ph      <= 3'b001;
      r_ph_adv  <= 3'b001;
      r_t5_cnt  <= '0;
      r_t1_cnt  <= '0;
      r_t_5ms   <= 1'b0;
      r_t_1s    <= 1'b0;
      r_lcdon   <= 1'b0;
      r_cpu_ack <= 1'b0;
    end else begin
      r_div     <= w_div_nxt;
      r_clk_ena <= (w_div_nxt == DIV_LAST);

      if (r_clk_ena)
        r_ph <= {r_ph[1:0], r_ph[2]};
      if (r_div == ADV_AT)
        r_ph_adv <= {r_ph_adv[1:0], r_ph_adv[2]};

      if (r_clk_ena) begin
        if (r_t5_cnt == T5_LAST) begin
          r_t5_cnt <= '0;
          r_t_5ms  <= ~r_t_5ms;
          if (r_t1_cnt == FL_LAST) begin
            r_t1_cnt <= '0;
            r_t_1s   <= ~r_t_1s;
          end else begin
            r_t1_cnt <= r_t1_cnt + FLW'(1);
          end
        end else begin
          r_t5_cnt <= r_t5_cnt + T5W'(1);
        end
      end

      if (w_lcd_upd)
        r_lcdon <= lcdon_req;

      r_cpu_ack <= r_clk_ena & w_mem_owner & cpu_req;
    end
  end

  assign clk_ena    = r_clk_ena;
  assign clk_ph     = r_ph;
  assign clk_ph_adv = r_ph_adv;
  assign t_5ms      = r_t_5ms;
  assign t_1s       = r_t_1s;
  assign lcdon      = r_lcdon;
  assign cpu_ack    = r_cpu_ack;

  assign mem_owner = w_mem_owner;
  assign mem_a     = w_mem_owner ? cpu_a : scr_va;
  assign mem_we    = w_mem_owner & cpu_req & cpu_we;
  assign cpu_wait  = cpu_req & ~w_mem_owner;

endmodule

// File: doc/screen_bus_seq.md
Name: screen_bus_seq

Overview:
- Master sequencer for the Z88 screen datapath and the shared memory bus.
- Generates the clock-enable strobe, the one-hot 3-phase cycle (clk_ph, clk_ph_adv) and the flash timebases (t_5ms, t_1s) consumed by the screen renderer.
- Arbitrates the single memory address bus between the renderer's video address and the Z80, and controls the LCD enable seen by the renderer.

Parameters:
- CLK_DIV, 4: master clk cycles per clk_ena pulse; even, >= 2.
- T5_TICKS, 16384: clk_ena pulses per t_5ms half-period.
- FLS_DIV, 200: t_5ms toggles per t_1s toggle.

Ports:
- clk  in  1  master clock.
- rin  in  1  synchronous active-high reset.
- lcdon_req  in  1  LCD enable request (Blink COM register bit).
- lcdon  out  1  effective LCD enable to the renderer.
- clk_ena  out  1  one-master-clock strobe, every CLK_DIV clocks.
- clk_ph  out  3  one-hot phase: [0] SBA LSB / pixel, [1] SBA MSB / counters, [2] ZAC (Z80 slot).
- clk_ph_adv  out  3  one-hot phase leading clk_ph by CLK_DIV/2 master clocks.
- t_5ms  out  1  grey timebase.
- t_1s  out  1  flash timebase.
- scr_va  in  22  renderer video address.
- cpu_a  in  22  Z80 address.
- cpu_req  in  1  Z80 access request, held until ack.
- cpu_we  in  1  Z80 write qualifier.
- cpu_ack  out  1  access complete pulse.
- cpu_wait  out  1  Z80 stall.
- mem_a  out  22  memory address.
- mem_we  out  1  memory write strobe.
- mem_owner  out  1  0 = screen, 1 = CPU.

Behaviour:
- One clock; reset is synchronous and active-high. rin is sampled on the rising edge of clk, and has priority over every other event.
- Reset values:
  - Internal: divider counter 0, t_5ms counter 0, t_1s counter 0.
  - Outputs: clk_ena 0, clk_ph 001, clk_ph_adv 001, t_5ms 0, t_1s 0, lcdon 0, cpu_ack 0.
- Divider:
  - Counter runs 0..CLK_DIV-1 and wraps.
  - clk_ena is registered high for exactly the cycle in which the counter equals CLK_DIV-1.
  - The first clk_ena after reset occurs CLK_DIV clocks after rin deasserts.
- Phase:
  - On each clock with clk_ena=1, clk_ph rotates left: 001 -> 010 -> 100 -> 001.
  - clk_ph_adv rotates identically, but on the clock where the divider counter equals CLK_DIV/2-1.
  - The one-hot property must hold on every cycle.
- Timebases:
  - The t_5ms counter increments on each clk_ena.
  - At T5_TICKS-1 the counter wraps to 0, t_5ms toggles, and the t_1s counter increments.
  - At FLS_DIV-1 the t_1s counter wraps and t_1s toggles, on the same edge as the t_5ms toggle.
- lcdon:
  - Follows lcdon_req, registered.
  - Updated only on clocks with clk_ena=1.
- Ownership (combinational from registered state):
  - mem_owner = !lcdon | clk_ph[2].
  - mem_a = mem_owner ? cpu_a : scr_va.
  - mem_we = mem_owner & cpu_req & cpu_we.
  - cpu_wait = cpu_req & !mem_owner.
- cpu_ack:
  - Registered; high for one master clock.
  - Set on a clock with clk_ena=1 & mem_owner=1 & cpu_req=1.
  - cpu_req may drop on the cycle after ack; a held request is re-served in the next owned phase.
- Boundary conditions:
  - lcdon=0: CPU owns every phase. cpu_ack can fire at every clk_ena; clk_ph keeps rotating.
  - cpu_req rising mid-phase in ph2: served at that phase's clk_ena, with no wait.
  - cpu_req rising in ph0/ph1: cpu_wait stays 1 until ph2.
  - Reset mid-access: cpu_ack is dropped; no pending state is retained.
  - lcdon changing between ph0 and ph1 (optional feature off): permitted; the renderer resets itself.

Optional Feature:
- Macro LCD_PHASE_SYNC_EN.
- Defined: lcdon updates only on a clk_ena where clk_ph=100, so the renderer always starts and stops at the ph2->ph0 boundary. An SBA LSB/MSB pair is therefore never split.
- Undefined: lcdon updates on any clk_ena.

Test Plan:
- Reset, then run 24 clocks with CLK_DIV=4 -> clk_ena high at clocks 4, 8, 12, ...; clk_ph sequence 010, 100, 001, 010...; clk_ph_adv changes 2 clocks before clk_ph; one-hot on every cycle.
- T5_TICKS=4, FLS_DIV=3 -> t_5ms toggles every 4 clk_ena; t_1s toggles every 12 clk_ena, coinciding with a t_5ms toggle.
- lcdon=1; cpu_req=1, cpu_we=1 raised in ph0 -> cpu_wait=1 through ph0/ph1; mem_a=scr_va; in ph2 mem_a=cpu_a, mem_we=1; cpu_ack single pulse at ph2 clk_ena; cpu_wait=0.
- lcdon_req=0 -> after the next clk_ena, mem_owner=1 in all phases; a held cpu_req acks on each clk_ena.
- With LCD_PHASE_SYNC_EN defined, raise lcdon_req in ph0 -> lcdon rises only at the clk_ena ending ph2; undefined -> lcdon rises at the next clk_ena.
- Assert rin during a pending ph2 access -> all outputs return to reset values on the next clock; no cpu_ack is issued.
